// File: rtl/time_set_ctrl.sv
// Time-of-day controller: synchronises the divider clocks and keys, debounces the keys, runs the RUN/SET mode FSM and BCD hh:mm:ss.
// Build option: define SET_BLINK_EN to flash the field being set at the synced 1 Hz rate.
`timescale 1ns/1ps

module tsc_debounce #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic smp_en_i,
  input  logic key_n_i,
  output logic press_o
);
  localparam logic [7:0] LAST = 8'(DEBOUNCE_MS - 1);

  logic       pressed;
  logic       stable_q, armed_q, press_q;
  logic [7:0] cnt_q;

  assign pressed = ~key_n_i;
  assign press_o = press_q;

  // armed_q stays low until the key has been seen released, so a key held through reset never fires
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b0;
      armed_q  <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      press_q <= 1'b0;
      if (smp_en_i) begin
        if (pressed != stable_q) begin
          if (cnt_q == LAST) begin
            stable_q <= pressed;
            cnt_q    <= 8'd0;
            press_q  <= pressed & armed_q;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end else begin
          cnt_q <= 8'd0;
        end
        if (!pressed) armed_q <= 1'b1;
      end
    end
  end
endmodule

module time_set_ctrl #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic       CLK_50,
  input  logic       nRST,
  input  logic       clk_1khz_in,
  input  logic       clk_1hz_in,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic [2:0] blink_mask,
  output logic       sec_tick,
  output logic       day_carry
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} mode_e;

  // sync lanes: [3] inc key, [2] mode key, [1] 1 Hz, [0] 1 kHz
  localparam logic [3:0] SYNC_RST = 4'b1100;

  logic [3:0] sync1_q, sync2_q;
  logic [1:0] prev_q;
  logic       ms_en, s_en, hz_lvl;
  logic [1:0] press;
  logic       mode_p, inc_p;

  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
      prev_q  <= 2'b00;
    end else begin
      sync1_q <= {key_inc_n, key_mode_n, clk_1hz_in, clk_1khz_in};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q[1:0];
    end
  end

  assign ms_en  = sync2_q[0] & ~prev_q[0];
  assign s_en   = sync2_q[1] & ~prev_q[1];
  assign hz_lvl = sync2_q[1];

  tsc_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db [1:0] (
    .clk_i    (CLK_50),
    .rst_ni   (nRST),
    .smp_en_i (ms_en),
    .key_n_i  (sync2_q[3:2]),
    .press_o  (press)
  );

  assign mode_p = press[0];
  assign inc_p  = press[1] & ~press[0];

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)          return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                   return {v[7:4], v[3:0] + 4'd1};
  endfunction

  mode_e      mode_q, mode_d;
  logic [7:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic       tick_q, tick_d, carry_q, carry_d;
  logic [2:0] blink_q, blink_d;

  // the action is chosen by the current mode; a mode press only changes what happens next cycle
  always_comb begin
    mode_d  = mode_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;
    carry_d = 1'b0;
    case (mode_q)
      RUN: if (s_en) begin
        tick_d = 1'b1;
        sec_d  = bcd_inc(sec_q, 8'h59);
        if (sec_q == 8'h59) begin
          min_d = bcd_inc(min_q, 8'h59);
          if (min_q == 8'h59) begin
            hour_d  = bcd_inc(hour_q, 8'h23);
            carry_d = (hour_q == 8'h23);
          end
        end
      end
      SET_HOUR: if (inc_p) hour_d = bcd_inc(hour_q, 8'h23);
      SET_MIN:  if (inc_p) min_d  = bcd_inc(min_q, 8'h59);
      SET_SEC:  if (inc_p) sec_d  = 8'h00;
      default: ;
    endcase
    if (mode_p) mode_d = mode_e'(2'(mode_q + 2'd1));

    blink_d = 3'b000;
`ifdef SET_BLINK_EN
    case (mode_d)
      SET_HOUR: blink_d[2] = hz_lvl;
      SET_MIN:  blink_d[1] = hz_lvl;
      SET_SEC:  blink_d[0] = hz_lvl;
      default: ;
    endcase
`else
    blink_d = {3{1'b0 & hz_lvl}};
`endif
  end

  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) begin
      mode_q  <= RUN;
      hour_q  <= 8'h00;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      tick_q  <= 1'b0;
      carry_q <= 1'b0;
      blink_q <= 3'b000;
    end else begin
      mode_q  <= mode_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      tick_q  <= tick_d;
      carry_q <= carry_d;
      blink_q <= blink_d;
    end
  end

  assign hour_bcd   = hour_q;
  assign min_bcd    = min_q;
  assign sec_bcd    = sec_q;
  assign mode       = mode_q;
  assign blink_mask = blink_q;
  assign sec_tick   = tick_q;
  assign day_carry  = carry_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomised scoreboard bench for time_set_ctrl; time is modelled as seconds-of-day.
`timescale 1ns/1ps

module tb_time_set_ctrl;
  localparam int DB = 20;

  logic       CLK_50 = 1'b0, nRST = 1'b0, khz = 1'b0, hz = 1'b0, kmode = 1'b1, kinc = 1'b1;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [1:0] mode;
  logic [2:0] blink_mask;
  logic       sec_tick, day_carry;

  time_set_ctrl #(.DEBOUNCE_MS(DB)) dut (
    .CLK_50(CLK_50), .nRST(nRST), .clk_1khz_in(khz), .clk_1hz_in(hz),
    .key_mode_n(kmode), .key_inc_n(kinc),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .mode(mode),
    .blink_mask(blink_mask), .sec_tick(sec_tick), .day_carry(day_carry)
  );

  always #10 CLK_50 = ~CLK_50;
  always begin repeat (2) @(negedge CLK_50); khz = ~khz; end

`ifdef SET_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct { int h; int m; int s; bit dc; } exp_t;
  exp_t q[$];
  int t_m = 0, mode_m = 0;
  int n_cmp = 0, n_err = 0, n_tick = 0, n_dc = 0;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string nm);
    chk({nm, "_mode"}, 32'(mode), 32'(mode_m));
    chk({nm, "_hour"}, 32'(hour_bcd), 32'(bcd(t_m / 3600)));
    chk({nm, "_min"},  32'(min_bcd),  32'(bcd((t_m / 60) % 60)));
    chk({nm, "_sec"},  32'(sec_bcd),  32'(bcd(t_m % 60)));
  endtask

  // monitor: every tick the DUT presents is matched against the next expected record
  always @(negedge CLK_50) if (nRST) begin
    if (sec_tick) begin
      n_tick++;
      if (day_carry) n_dc++;
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_tick: got tick at %0h:%0h:%0h want none", hour_bcd, min_bcd, sec_bcd);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("tick_hour", 32'(hour_bcd), 32'(bcd(e.h)));
        chk("tick_min",  32'(min_bcd),  32'(bcd(e.m)));
        chk("tick_sec",  32'(sec_bcd),  32'(bcd(e.s)));
        chk("tick_dc",   32'(day_carry), 32'(e.dc));
      end
    end else if (day_carry) begin
      n_dc++; n_cmp++; n_err++;
      $display("FAIL carry_no_tick: got day_carry=1 want 0");
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_50);
  endtask

  task automatic wait_ms(input int n);
    repeat (n) @(posedge khz);
    @(negedge CLK_50);
  endtask

  task automatic hz_edge();
    exp_t e;
    @(negedge CLK_50);
    hz = 1'b1;
    if (mode_m == 0) begin
      t_m = (t_m + 1) % 86400;
      e.h = t_m / 3600; e.m = (t_m / 60) % 60; e.s = t_m % 60; e.dc = (t_m == 0);
      q.push_back(e);
    end
    cyc($urandom_range(4, 8));
    hz = 1'b0;
    cyc($urandom_range(4, 8));
  endtask

  task automatic model_press(input bit m, input bit i);
    int h, mi, s;
    h = t_m / 3600; mi = (t_m / 60) % 60; s = t_m % 60;
    if (m) mode_m = (mode_m + 1) % 4;
    else if (i) begin
      case (mode_m)
        1: h  = (h + 1) % 24;
        2: mi = (mi + 1) % 60;
        3: s  = 0;
        default: ;
      endcase
      t_m = h * 3600 + mi * 60 + s;
    end
  endtask

  task automatic press(input bit m, input bit i, input int bounces);
    for (int b = 0; b < bounces; b++) begin
      kmode = ~m; kinc = ~i;
      wait_ms($urandom_range(1, 6));
      kmode = 1'b1; kinc = 1'b1;
      wait_ms($urandom_range(2, 3));
    end
    kmode = ~m; kinc = ~i;
    wait_ms(DB + 3 + $urandom_range(0, 3));
    model_press(m, i);
    kmode = 1'b1; kinc = 1'b1;
    wait_ms(DB + 3);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) press(1'b0, 1'b1, $urandom_range(0, 2));
  endtask

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, dc0;
    cyc(3);
    chk_state("reset");
    chk("reset_blink", 32'(blink_mask), 32'd0);
    chk("reset_tick",  32'(sec_tick),   32'd0);
    chk("reset_dc",    32'(day_carry),  32'd0);
    nRST = 1'b1;
    wait_ms(3);

    // seconds counting
    repeat (3) hz_edge();
    cyc(4);
    chk("t1_sec", 32'(sec_bcd), 32'h03);
    chk("t1_ticks", n_tick, 3);
    chk("t1_dc", n_dc, 0);

    // debounce: glitches never step the mode, steady press steps once
    kmode = 1'b0; wait_ms(5);
    for (int b = 0; b < 4; b++) begin
      kmode = 1'b1; wait_ms($urandom_range(2, 3));
      kmode = 1'b0; wait_ms($urandom_range(3, 6));
    end
    chk("db_glitch", 32'(mode), 32'd0);
    wait_ms(25);
    chk("db_press", 32'(mode), 32'd1);
    kmode = 1'b1; wait_ms(DB + 3);
    mode_m = 1;
    chk("db_release", 32'(mode), 32'd1);

    // set hours with 1 Hz edges interleaved
    base = n_tick;
    for (int k = 0; k < 25; k++) begin
      press(1'b0, 1'b1, $urandom_range(0, 2));
      if (k % 2 == 0 && k < 20) hz_edge();
    end
    chk_state("t4");
    chk("t4_hour", 32'(hour_bcd), 32'h01);
    chk("t4_sec", 32'(sec_bcd), 32'h03);
    chk("t4_ticks", n_tick, base);
    hz = 1'b1; cyc(6);
    chk("blink_hour_hi", 32'(blink_mask), BLINK ? 32'd4 : 32'd0);
    hz = 1'b0; cyc(6);
    chk("blink_hour_lo", 32'(blink_mask), 32'd0);

    // simultaneous presses in SET_MIN
    press(1'b1, 1'b0, 1);
    incs(7);
    chk("t5_min07", 32'(min_bcd), 32'h07);
    press(1'b1, 1'b1, 0);
    chk_state("t5");
    chk("t5_mode", 32'(mode), 32'd3);
    chk("t5_min", 32'(min_bcd), 32'h07);
    hz = 1'b1; cyc(6);
    chk("blink_sec_hi", 32'(blink_mask), BLINK ? 32'd1 : 32'd0);
    hz = 1'b0; cyc(6);
    chk("blink_sec_lo", 32'(blink_mask), 32'd0);
    incs(1);
    press(1'b1, 1'b0, 0);
    chk_state("run_again");
    chk("run_blink", 32'(blink_mask), 32'd0);

    // set 23:59:00 and roll the day
    press(1'b1, 1'b0, 0); incs(22);
    press(1'b1, 1'b0, 0); incs(52);
    press(1'b1, 1'b0, 0); press(1'b1, 1'b0, 0);
    chk_state("t2_set");
    repeat (59) hz_edge();
    cyc(4);
    chk("t2_sec59", 32'(sec_bcd), 32'h59);
    dc0 = n_dc; base = n_tick;
    hz_edge();
    cyc(4);
    chk("t2_hour", 32'(hour_bcd), 32'h00);
    chk("t2_min", 32'(min_bcd), 32'h00);
    chk("t2_sec", 32'(sec_bcd), 32'h00);
    chk("t2_dc", n_dc, dc0 + 1);
    chk("t2_tick", n_tick, base + 1);

    // reach SET_MIN at 12:34:56 then reset with the mode key held
    repeat (56) hz_edge();
    press(1'b1, 1'b0, 0); incs(12);
    press(1'b1, 1'b0, 0); incs(34);
    chk("t6_hour", 32'(hour_bcd), 32'h12);
    chk("t6_min", 32'(min_bcd), 32'h34);
    chk("t6_sec", 32'(sec_bcd), 32'h56);
    chk_state("t6_pre");
    kmode = 1'b0; wait_ms(5);
    nRST = 1'b0; #1;
    t_m = 0; mode_m = 0;
    chk_state("t6_rst");
    chk("t6_blink", 32'(blink_mask), 32'd0);
    @(negedge CLK_50); nRST = 1'b1;
    wait_ms(30);
    chk("t6_held", 32'(mode), 32'd0);
    kmode = 1'b1; wait_ms(25);
    chk("t6_released", 32'(mode), 32'd0);
    press(1'b1, 1'b0, 0);
    chk_state("t6_repress");

    cyc(20);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Time-of-day controller driven by the divider outputs (1 kHz and 1 Hz square waves derived from CLK_50). It debounces two pushbuttons and runs a RUN/SET state machine. It keeps BCD hour/minute/second counters that advance on the 1 Hz edge or are adjusted in set mode. It sits between the clock divider and the display/date logic, and emits second and day-carry pulses for the downstream calendar counter.

## Interface
- DEBOUNCE_MS, 20: consecutive 1 kHz samples a key must hold a new level before it is accepted (range 1–255).
- CLK_50  in  1  system clock, 50 MHz.
- nRST  in  1  asynchronous active-low reset.
- clk_1khz_in  in  1  1 kHz square wave from divider, CLK_50-synchronous.
- clk_1hz_in  in  1  1 Hz square wave from divider, CLK_50-synchronous.
- key_mode_n  in  1  mode pushbutton, active-low, asynchronous, bouncy.
- key_inc_n  in  1  increment pushbutton, active-low, asynchronous, bouncy.
- hour_bcd  out  8  hours 00–23, BCD (tens [7:4], units [3:0]).
- min_bcd  out  8  minutes 00–59, BCD.
- sec_bcd  out  8  seconds 00–59, BCD.
- mode  out  2  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
- blink_mask  out  3  display blank request: bit2 hour, bit1 min, bit0 sec.
- sec_tick  out  1  one-cycle pulse coincident with each RUN-mode second increment.
- day_carry  out  1  one-cycle pulse when 23:59:59 rolls to 00:00:00 in RUN.

## Operation
- **Synchronisation:** all four inputs pass through 2-FF synchronisers.
  - ms_en is the rising edge of the synced clk_1khz_in.
  - s_en is the rising edge of the synced clk_1hz_in.
  - Each enable is one CLK_50 cycle wide.
- **Debounce (per key):**
  - The stable state resets to released.
  - On each ms_en: if the synced key ≠ stable, the count increments; otherwise the count clears.
  - When the count reaches DEBOUNCE_MS, stable takes the new level and the count clears.
  - A press pulse (one cycle) is generated when stable goes released→pressed. Release generates nothing.
- **State machine:**
  - On mode press: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
  - In RUN the inc press is ignored.
  - SET_HOUR: hour +1, 23→00.
  - SET_MIN: min +1, 59→00.
  - SET_SEC: sec clears to 00.
  - In SET modes, no carry propagates into other fields.
- **Timekeeping:**
  - In RUN, on s_en: sec +1 with BCD carry 59→00 into min, then 59→00 into hour, then 23→00.
  - sec_tick is asserted on every RUN increment.
  - day_carry is asserted only on the 23:59:59→00:00:00 transition.
  - In SET modes, s_en is ignored and the time is frozen.
- **BCD arithmetic:** units wrap 9→0 with tens +1. No field ever holds a non-BCD or out-of-range value.
- **Simultaneous events:**
  - Mode and inc press in the same cycle: mode wins, inc is discarded.
  - s_en and mode press in the same cycle while in RUN: the increment applies and the state advances. Actions are decided by the current state.
- **Reset values:**
  - Outputs: time 00:00:00, mode 0, blink_mask 0, sec_tick 0, day_carry 0.
  - Internal: debounce stable = released, counters 0.
  - Reset mid-operation (any state) returns immediately to these values.

## Timing
- Input edge to enable: an input edge sampled at CLK_50 edge k produces s_en/ms_en high in the cycle after edge k+1.
- Time registers, sec_tick and day_carry update at edge k+2. They are registered and change together.
- Key press latency: 2 cycles of synchronisation, plus DEBOUNCE_MS ms_en samples, plus 1 cycle. mode or the time field updates on the edge after the press pulse.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- **SET_BLINK_EN defined:** in a SET mode, the blink_mask bit for the selected field equals the synced clk_1hz_in level, so the field flashes at 1 Hz.
- **SET_BLINK_EN undefined:** that bit is held at 0, so the field stays lit, and the mode output alone identifies the field.
- In RUN, blink_mask = 0 in both builds.

## Test plan
The bench may drive clk_1khz_in and clk_1hz_in faster than nominal, e.g. periods of 20 and 200 CLK_50 cycles.

1. **Seconds counting:** reset, then 3 clk_1hz_in rising edges → sec_bcd 0x00→0x03, exactly 3 sec_tick pulses, day_carry never high.
2. **Day rollover:** set 23:59:xx, return to RUN, advance until sec 0x59, one more 1 Hz edge → 00:00:00, one sec_tick and one day_carry pulse in the same cycle.
3. **Debounce:** with DEBOUNCE_MS=20, key_mode_n low for 5 ms-samples, bouncing ×4, then steady low for 25 samples → exactly one press; mode 0→1, no step on the glitches.
4. **Set hours:** in SET_HOUR from 00, 25 inc presses → hour_bcd 0x01. Ten clk_1hz_in edges during this → sec_bcd and min_bcd unchanged, no sec_tick.
5. **Simultaneous presses:** in SET_MIN with min 0x07, mode and inc press in the same cycle → mode 3, min_bcd stays 0x07. With SET_BLINK_EN, blink_mask bit0 toggles with clk_1hz_in; without it, blink_mask = 0.
6. **Reset mid-operation:** nRST low for 1 cycle during SET_MIN at 12:34:56 → immediately 00:00:00, mode 0, blink_mask 0. A key held across the reset produces no press until it is released and pressed again.
